eth_frame_gen: RTL and testbench
================================

ETH_FRAME_GEN -- requirements
Module: eth_frame_gen

Interface
REQ-001 Parameter DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC placed in frame bytes 0-5.
REQ-002 Parameter SRC_MAC, 48'h0200_0000_0001, source MAC placed in frame bytes 6-11.
REQ-003 Parameter ETHERTYPE, 16'h88B5, placed in frame bytes 12-13.
REQ-004 Parameter PAYLOAD_LEN, 46, payload byte count; legal range 46..1500.
REQ-005 Parameter IFG_CYCLES, 24, idle clocks between frames; legal range 1..255.
REQ-006 clk_tx  in  1  single clock, Ethernet TX clock domain; all logic on rising edge.
REQ-007 rstn  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  single-frame request, sampled in IDLE only.
REQ-009 continuous  in  1  when high, frames are generated back-to-back, separated by the IFG.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 frame_cnt  out  32  count of frames whose last nibble was accepted.
REQ-012 tx_vld  out  1  nibble stream valid.
REQ-013 tx_dat  out  4  nibble data.
REQ-014 tx_eof  out  1  marks last nibble of frame; valid only with tx_vld.
REQ-015 tx_ack  in  1  consumer (tx_mac) accepts the current nibble when tx_vld and tx_ack are both high.

Function
REQ-016 States IDLE, HDR, PAY, GAP; reset state IDLE.
REQ-017 IDLE -> HDR on the cycle after start or continuous is sampled high; start is ignored outside IDLE.
REQ-018 tx_vld goes high on the first HDR cycle; no combinational path from start to tx_vld.
REQ-019 Byte order: bytes 0-13 header (MACs and ETHERTYPE, MSB byte first), then PAYLOAD_LEN payload bytes.
REQ-020 Nibble order: low nibble of each byte first, then high nibble (MII order).
REQ-021 Payload byte k = (seq + k) mod 256; seq = frame_cnt[7:0] latched on IDLE/GAP exit.
REQ-022 tx_dat, tx_eof and tx_vld hold stable while tx_vld=1 and tx_ack=0; the stream advances one nibble per accepted cycle.
REQ-023 HDR -> PAY after the high nibble of byte 13 is accepted.
REQ-024 tx_eof=1 only on the high nibble of the last payload byte; frame length = 2*(14+PAYLOAD_LEN) nibbles.
REQ-025 PAY -> GAP on acceptance of the eof nibble; frame_cnt increments on that same edge and wraps 2^32-1 -> 0.
REQ-026 GAP holds tx_vld=0 for exactly IFG_CYCLES clocks; then -> HDR if continuous=1, else -> IDLE.
REQ-027 Dropping continuous mid-frame completes the current frame and then its gap; the frame is never truncated.
REQ-028 Byte counter is 11 bits; nibble phase is 1 bit; gap counter is 8 bits.
REQ-029 tx_ack while tx_vld=0 has no effect.

Reset
REQ-030 On rstn low: state IDLE, tx_vld=0, tx_eof=0, tx_dat=0, busy=0, frame_cnt=0, all counters 0, asynchronously.
REQ-031 Reset asserted mid-frame abandons the frame with no eof; after release, the generator waits in IDLE for start/continuous.
REQ-032 Reset deassertion is synchronised externally; the module does not require a start within N cycles of release.

Structure
REQ-033 Shared package eth_pkg holds the state enum, header length constant (14), and min/max payload constants (46/1500).
REQ-034 Single flat module, with no sub-modules; the header is a 112-bit constant vector indexed by byte counter.

Verification
REQ-035 tx_ack tied 1, start pulse, defaults: 120 nibbles; first 12 nibbles F; nibbles 12-13 = 2,0; nibbles 24-27 = 8,8,5,B; tx_eof on nibble 120; frame_cnt=1; busy low 24 cycles after eof.
REQ-036 Random tx_ack (50%): the captured byte stream is identical to REQ-035; tx_dat/tx_eof are unchanged across every stalled cycle.
REQ-037 continuous=1 for 3 frames with tx_ack=1: the gap between frames is exactly 24 tx_vld=0 cycles; payload byte 0 of frames 0,1,2 = 00,01,02.
REQ-038 rstn asserted at nibble 50 of a frame: all outputs 0 immediately; with no start after release, there is no tx_vld; a later start sends a full frame and frame_cnt=1.
REQ-039 start pulsed during PAY and during GAP: it is ignored, and exactly one frame is produced.
REQ-040 frame_cnt forced near wrap (0xFFFFFFFF) via continuous run: frame_cnt wraps to 0 and the next payload starts at 00.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet test-frame generator.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int HDR_LEN     = 14;
    localparam int MIN_PAYLOAD = 46;
    localparam int MAX_PAYLOAD = 1500;

endpackage

// File: rtl/eth_frame_gen.sv
// Generates fixed-header Ethernet frames with an incrementing payload as an MII-ordered
// nibble stream with valid/ack handshake, optional back-to-back mode and inter-frame gap.
module eth_frame_gen
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          PAYLOAD_LEN = 46,
    parameter int          IFG_CYCLES  = 24
) (
    input  logic        clk_tx,
    input  logic        rstn,
    input  logic        start,
    input  logic        continuous,
    output logic        busy,
    output logic [31:0] frame_cnt,
    output logic        tx_vld,
    output logic [3:0]  tx_dat,
    output logic        tx_eof,
    input  logic        tx_ack
);

    // Out-of-range parameters are clamped to the legal range rather than producing odd frames.
    localparam int PAY_BYTES = (PAYLOAD_LEN < MIN_PAYLOAD) ? MIN_PAYLOAD :
                               (PAYLOAD_LEN > MAX_PAYLOAD) ? MAX_PAYLOAD : PAYLOAD_LEN;
    localparam int IFG       = (IFG_CYCLES < 1) ? 1 : (IFG_CYCLES > 255) ? 255 : IFG_CYCLES;

    localparam logic [111:0] HDR_VEC   = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [10:0]  LAST_HDR  = 11'(HDR_LEN - 1);
    localparam logic [10:0]  LAST_BYTE = 11'(HDR_LEN + PAY_BYTES - 1);
    localparam logic [7:0]   LAST_GAP  = 8'(IFG - 1);
    localparam logic [7:0]   HDR_OFS   = 8'(HDR_LEN);

    state_t      state, next_state;
    logic [10:0] byte_cnt;
    logic        phase;
    logic [7:0]  gap_cnt;
    logic [7:0]  seq;
    logic [7:0]  cur_byte;
    logic        accept;
    logic        hdr_done;
    logic        eof_nib;

    assign accept   = tx_vld && tx_ack;
    assign hdr_done = phase && (byte_cnt == LAST_HDR);
    assign eof_nib  = phase && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk_tx or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start || continuous) next_state = HDR;
            HDR:  if (accept && hdr_done)  next_state = PAY;
            PAY:  if (accept && eof_nib)   next_state = GAP;
            GAP:  if (gap_cnt == LAST_GAP) next_state = continuous ? HDR : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Header byte 0 sits in the top byte of HDR_VEC, so shift down by (13 - index) bytes.
    always_comb begin
        cur_byte = 8'h00;
        if (state == HDR) begin
            cur_byte = 8'(HDR_VEC >> {4'(LAST_HDR[3:0] - byte_cnt[3:0]), 3'b000});
        end else if (state == PAY) begin
            cur_byte = seq + byte_cnt[7:0] - HDR_OFS;
        end
    end

    always_comb begin
        busy   = (state != IDLE);
        tx_vld = (state == HDR) || (state == PAY);
        tx_eof = (state == PAY) && eof_nib;
        tx_dat = 4'h0;
        if (tx_vld) begin
            tx_dat = phase ? cur_byte[7:4] : cur_byte[3:0];
        end
    end

    always_ff @(posedge clk_tx or negedge rstn) begin
        if (!rstn) begin
            byte_cnt  <= '0;
            phase     <= 1'b0;
            gap_cnt   <= '0;
            seq       <= '0;
            frame_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (next_state == HDR) begin
                        seq      <= frame_cnt[7:0];
                        byte_cnt <= '0;
                        phase    <= 1'b0;
                    end
                end
                HDR, PAY: begin
                    if (accept) begin
                        phase <= ~phase;
                        if (state == PAY && eof_nib) begin
                            byte_cnt  <= '0;
                            gap_cnt   <= '0;
                            frame_cnt <= frame_cnt + 32'd1;
                        end else if (phase) begin
                            byte_cnt <= byte_cnt + 11'd1;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                    // frame_cnt already counts the frame just sent, so the next frame's seq follows it.
                    if (next_state != GAP) begin
                        gap_cnt <= '0;
                        seq     <= frame_cnt[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Scoreboard bench for eth_frame_gen: expected nibbles are queued when a frame is requested
// and popped as the generator hands nibbles over.
module tb_eth_frame_gen;

    logic        clk_tx = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        tx_ack = 1'b0;
    logic        busy;
    logic [31:0] frame_cnt;
    logic        tx_vld;
    logic [3:0]  tx_dat;
    logic        tx_eof;

    eth_frame_gen dut (
        .clk_tx     (clk_tx),
        .rstn       (rstn),
        .start      (start),
        .continuous (continuous),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .tx_vld     (tx_vld),
        .tx_dat     (tx_dat),
        .tx_eof     (tx_eof),
        .tx_ack     (tx_ack)
    );

    always #5 clk_tx = ~clk_tx;

    localparam int FRAME_NIBS = 120;

    int          total = 0;
    int          bad = 0;
    logic [4:0]  exp_q[$];
    logic [3:0]  cap[$];
    int          gap_q[$];
    bit          ack_rand = 1'b0;
    logic [31:0] exp_cnt = 32'd0;

    logic        st_pend = 1'b0;
    logic [3:0]  st_dat;
    logic        st_eof;
    bit          eof_seen = 1'b0;
    int          gap_run = 0;

    // Expected frame: header constants, then (seq + k) mod 256, low nibble first.
    task automatic push_frame(input logic [7:0] seq);
        logic [111:0] hdr;
        logic [7:0]   b;
        hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};
        for (int i = 0; i < 60; i++) begin
            if (i < 14) b = hdr[111 - 8*i -: 8];
            else        b = seq + 8'(i - 14);
            exp_q.push_back({1'b0, b[3:0]});
            exp_q.push_back({(i == 59), b[7:4]});
        end
    endtask

    always @(posedge clk_tx) begin
        #1;
        tx_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk_tx) begin
        if (!rstn) begin
            st_pend  = 1'b0;
            eof_seen = 1'b0;
            gap_run  = 0;
        end else begin
            if (st_pend) begin
                total++;
                if (tx_vld !== 1'b1 || tx_dat !== st_dat || tx_eof !== st_eof) begin
                    bad++;
                    $display("FAIL stall_hold: got vld=%b dat=%h eof=%b, want vld=1 dat=%h eof=%b",
                             tx_vld, tx_dat, tx_eof, st_dat, st_eof);
                end
            end
            st_pend = (tx_vld === 1'b1) && (tx_ack !== 1'b1);
            st_dat  = tx_dat;
            st_eof  = tx_eof;
            if (eof_seen && tx_vld === 1'b0) gap_run++;
            if (eof_seen && tx_vld === 1'b1) begin
                gap_q.push_back(gap_run);
                eof_seen = 1'b0;
            end
            if (tx_vld === 1'b1 && tx_ack === 1'b1) begin
                logic [4:0] e;
                cap.push_back(tx_dat);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_nibble: got dat=%h eof=%b, want no nibble", tx_dat, tx_eof);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_eof, tx_dat} !== e) begin
                        bad++;
                        $display("FAIL nibble_%0d: got eof=%b dat=%h, want eof=%b dat=%h",
                                 cap.size() - 1, tx_eof, tx_dat, e[4], e[3:0]);
                    end
                end
                if (tx_eof === 1'b1) begin
                    eof_seen = 1'b1;
                    gap_run  = 0;
                end
            end
        end
    end

    task automatic do_reset();
        start = 1'b0;
        continuous = 1'b0;
        @(negedge clk_tx);
        rstn = 1'b0;
        repeat (2) @(negedge clk_tx);
        exp_q.delete();
        cap.delete();
        gap_q.delete();
        exp_cnt = 32'd0;
        rstn = 1'b1;
        @(negedge clk_tx);
    endtask

    task automatic pulse_start();
        @(negedge clk_tx);
        start = 1'b1;
        @(negedge clk_tx);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_tx);
            if (busy === 1'b0 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({busy, tx_vld, tx_eof, tx_dat} !== 7'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b vld=%b eof=%b dat=%h, want all 0",
                     busy, tx_vld, tx_eof, tx_dat);
        end
        total++;
        if (frame_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_frame_cnt: got %h, want 0", frame_cnt);
        end
        repeat (2) @(negedge clk_tx);
        rstn = 1'b1;
        @(negedge clk_tx);
    endtask

    task automatic test_basic();
        bit found;
        int n;
        bit allf;
        found = 1'b0;
        push_frame(exp_cnt[7:0]);
        exp_cnt++;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_tx);
            if (tx_vld === 1'b1 && tx_ack === 1'b1 && tx_eof === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL basic_eof_timeout: got no eof, want eof within 400 cycles");
        end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_tx);
            if (busy !== 1'b1) break;
            n++;
        end
        total++;
        if (n != 24) begin
            bad++;
            $display("FAIL basic_busy_after_eof: got %0d cycles, want 24", n);
        end
        total++;
        if (cap.size() != FRAME_NIBS) begin
            bad++;
            $display("FAIL basic_length: got %0d nibbles, want %0d", cap.size(), FRAME_NIBS);
        end else begin
            allf = 1'b1;
            for (int i = 0; i < 12; i++) if (cap[i] !== 4'hF) allf = 1'b0;
            total++;
            if (!allf) begin
                bad++;
                $display("FAIL basic_dst_mac: got non-F nibble in 0..11, want all F");
            end
            total++;
            if ({cap[12], cap[13]} !== 8'h20) begin
                bad++;
                $display("FAIL basic_src_byte0: got %h,%h, want 2,0", cap[12], cap[13]);
            end
            total++;
            if ({cap[24], cap[25], cap[26], cap[27]} !== 16'h885B) begin
                bad++;
                $display("FAIL basic_ethertype: got %h%h%h%h, want 885B", cap[24], cap[25], cap[26], cap[27]);
            end
        end
        total++;
        if (frame_cnt !== 32'd1) begin
            bad++;
            $display("FAIL basic_frame_cnt: got %0d, want 1", frame_cnt);
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        ack_rand = 1'b1;
        push_frame(exp_cnt[7:0]);
        exp_cnt++;
        pulse_start();
        wait_done(ok);
        ack_rand = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stall_timeout: got busy=%b left=%0d, want idle with 0 left", busy, exp_q.size());
        end
        total++;
        if (cap.size() != FRAME_NIBS || frame_cnt !== 32'd1) begin
            bad++;
            $display("FAIL stall_frame: got %0d nibbles cnt=%0d, want %0d nibbles cnt=1",
                     cap.size(), frame_cnt, FRAME_NIBS);
        end
    endtask

    task automatic test_continuous();
        bit ok;
        bit reached;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            push_frame(exp_cnt[7:0]);
            exp_cnt++;
        end
        @(negedge clk_tx);
        continuous = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_tx);
            if (cap.size() > 2 * FRAME_NIBS) begin
                reached = 1'b1;
                break;
            end
        end
        continuous = 1'b0;
        wait_done(ok);
        total++;
        if (!reached || !ok) begin
            bad++;
            $display("FAIL cont_timeout: got reached=%b done=%b, want 1 1", reached, ok);
        end
        total++;
        if (gap_q.size() != 2 || gap_q[0] != 24 || gap_q[1] != 24) begin
            bad++;
            $display("FAIL cont_gap: got %0d gaps first=%0d, want 2 gaps of 24",
                     gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1);
        end
        total++;
        if (cap.size() != 3 * FRAME_NIBS) begin
            bad++;
            $display("FAIL cont_length: got %0d nibbles, want %0d", cap.size(), 3 * FRAME_NIBS);
        end else begin
            total++;
            if ({cap[28], cap[29], cap[148], cap[149], cap[268], cap[269]} !== 24'h001020) begin
                bad++;
                $display("FAIL cont_payload0: got %h%h %h%h %h%h, want 00 10 20 (lo,hi)",
                         cap[28], cap[29], cap[148], cap[149], cap[268], cap[269]);
            end
        end
        total++;
        if (frame_cnt !== 32'd3) begin
            bad++;
            $display("FAIL cont_frame_cnt: got %0d, want 3", frame_cnt);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit reached;
        int stray;
        do_reset();
        push_frame(exp_cnt[7:0]);
        pulse_start();
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_tx);
            if (cap.size() >= 50) begin
                reached = 1'b1;
                break;
            end
        end
        rstn = 1'b0;
        #1;
        total++;
        if (!reached || {busy, tx_vld, tx_eof, tx_dat} !== 7'd0 || frame_cnt !== 32'd0) begin
            bad++;
            $display("FAIL abort_outputs: got reached=%b busy=%b vld=%b eof=%b dat=%h cnt=%0d, want 1 and all 0",
                     reached, busy, tx_vld, tx_eof, tx_dat, frame_cnt);
        end
        repeat (2) @(negedge clk_tx);
        exp_q.delete();
        cap.delete();
        exp_cnt = 32'd0;
        rstn = 1'b1;
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_tx);
            if (tx_vld !== 1'b0 || busy !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL abort_idle: got %0d active cycles, want 0", stray);
        end
        push_frame(exp_cnt[7:0]);
        exp_cnt++;
        pulse_start();
        wait_done(ok);
        total++;
        if (!ok || cap.size() != FRAME_NIBS || frame_cnt !== 32'd1) begin
            bad++;
            $display("FAIL abort_restart: got done=%b %0d nibbles cnt=%0d, want 1 %0d 1",
                     ok, cap.size(), frame_cnt, FRAME_NIBS);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        bit found;
        int stray;
        do_reset();
        push_frame(exp_cnt[7:0]);
        exp_cnt++;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_tx);
            if (cap.size() >= 60) break;
        end
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_tx);
            if (tx_vld === 1'b1 && tx_ack === 1'b1 && tx_eof === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        repeat (5) @(negedge clk_tx);
        pulse_start();
        wait_done(ok);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_tx);
            if (tx_vld !== 1'b0 || busy !== 1'b0) stray++;
        end
        total++;
        if (!found || !ok || stray != 0) begin
            bad++;
            $display("FAIL ignore_start_flow: got eof=%b done=%b stray=%0d, want 1 1 0", found, ok, stray);
        end
        total++;
        if (cap.size() != FRAME_NIBS || frame_cnt !== 32'd1) begin
            bad++;
            $display("FAIL ignore_start_count: got %0d nibbles cnt=%0d, want %0d nibbles cnt=1",
                     cap.size(), frame_cnt, FRAME_NIBS);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        bit reached;
        logic [31:0] mid_cnt;
        do_reset();
        force dut.frame_cnt = 32'hFFFF_FFFF;
        @(negedge clk_tx);
        release dut.frame_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        push_frame(exp_cnt[7:0]);
        exp_cnt++;
        push_frame(exp_cnt[7:0]);
        exp_cnt++;
        @(negedge clk_tx);
        continuous = 1'b1;
        reached = 1'b0;
        mid_cnt = 32'hDEAD_BEEF;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_tx);
            if (cap.size() > FRAME_NIBS) begin
                reached = 1'b1;
                mid_cnt = frame_cnt;
                break;
            end
        end
        continuous = 1'b0;
        total++;
        if (!reached || mid_cnt !== 32'd0) begin
            bad++;
            $display("FAIL wrap_cnt: got reached=%b cnt=%h, want 1 00000000", reached, mid_cnt);
        end
        wait_done(ok);
        total++;
        if (!ok || cap.size() != 2 * FRAME_NIBS) begin
            bad++;
            $display("FAIL wrap_length: got done=%b %0d nibbles, want 1 %0d", ok, cap.size(), 2 * FRAME_NIBS);
        end else begin
            total++;
            if ({cap[28], cap[29], cap[148], cap[149]} !== 16'hFF00) begin
                bad++;
                $display("FAIL wrap_payload0: got %h%h %h%h, want FF 00", cap[28], cap[29], cap[148], cap[149]);
            end
        end
        total++;
        if (frame_cnt !== 32'd1) begin
            bad++;
            $display("FAIL wrap_final_cnt: got %h, want 00000001", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_continuous();
        test_abort();
        test_start_ignored();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
